// File: rtl/tinytone_pkg.sv
// Shared types and defaults for the tinytone run-time controller.
package tinytone_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SOUND  = 2'd1,
    ST_GAP    = 2'd2,
    ST_PAUSED = 2'd3
  } seq_state_e;

  localparam int unsigned CNT_BW_DEFAULT  = 24;
  localparam int unsigned IDX_BW_DEFAULT  = 6;
  localparam int unsigned SEQ_LEN_DEFAULT = 32;

  localparam logic [23:0] TEMPO_DEFAULT = 24'd2400000;
  localparam logic [23:0] GAP_DEFAULT   = 24'd240000;

endpackage

// File: rtl/tempo_counter.sv
// Slot counter with latched (clamped) tempo/gap and the sound->gap and
// end-of-slot compare flags.
module tempo_counter #(
  parameter int unsigned CNT_BW = 24
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              en_i,
  input  logic [CNT_BW-1:0] tempo_i,
  input  logic [CNT_BW-1:0] gap_i,
  output logic              gap_zero_o,
  output logic              gap_hit_o,
  output logic              slot_end_o
);

  localparam logic [CNT_BW-1:0] ONE = CNT_BW'(1);

  logic [CNT_BW-1:0] cnt_q, cnt_d;
  logic [CNT_BW-1:0] tempo_l_q, tempo_l_d;
  logic [CNT_BW-1:0] gap_l_q, gap_l_d;
  logic [CNT_BW-1:0] tempo_clamp;
  logic [CNT_BW-1:0] gap_clamp;

  // Tempo of 0 is treated as 1; gap is capped so the gate lasts >= 1 cycle.
  always_comb begin
    tempo_clamp = (tempo_i == '0) ? ONE : tempo_i;
    gap_clamp   = (gap_i > (tempo_clamp - ONE)) ? (tempo_clamp - ONE) : gap_i;
  end

  always_comb begin
    cnt_d     = cnt_q;
    tempo_l_d = tempo_l_q;
    gap_l_d   = gap_l_q;
    if (load_i) begin
      cnt_d     = '0;
      tempo_l_d = tempo_clamp;
      gap_l_d   = gap_clamp;
    end else if (en_i) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      tempo_l_q <= '0;
      gap_l_q   <= '0;
    end else begin
      cnt_q     <= cnt_d;
      tempo_l_q <= tempo_l_d;
      gap_l_q   <= gap_l_d;
    end
  end

  always_comb begin
    gap_zero_o = (gap_l_q == '0);
    gap_hit_o  = !gap_zero_o && (cnt_q == (tempo_l_q - gap_l_q - ONE));
    slot_end_o = (cnt_q == (tempo_l_q - ONE));
  end

endmodule

// File: rtl/note_sequencer_ctrl.sv
// Run-time sequencer: steps the note index, emits note-on, gate, busy and
// done with start/stop/pause/loop control and a programmable tempo.
module note_sequencer_ctrl
  import tinytone_pkg::*;
#(
  parameter int unsigned CNT_BW  = CNT_BW_DEFAULT,
  parameter int unsigned IDX_BW  = IDX_BW_DEFAULT,
  parameter int unsigned SEQ_LEN = SEQ_LEN_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              pause_i,
  input  logic              loop_i,
  input  logic [CNT_BW-1:0] tempo_i,
  input  logic [CNT_BW-1:0] gap_i,
  output logic [IDX_BW-1:0] note_index_o,
  output logic              note_on_o,
  output logic              gate_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [IDX_BW-1:0] LAST_IDX = IDX_BW'(SEQ_LEN - 1);

  seq_state_e        state_q, state_d;
  seq_state_e        resume_q, resume_d;
  logic [IDX_BW-1:0] idx_q, idx_d;
  logic              note_on_q, note_on_d;
  logic              gate_q, gate_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic load;
  logic advance;
  logic cnt_en;
  logic gap_zero;
  logic gap_hit;
  logic slot_end;

  tempo_counter #(
    .CNT_BW(CNT_BW)
  ) u_tempo_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load),
    .en_i       (cnt_en),
    .tempo_i    (tempo_i),
    .gap_i      (gap_i),
    .gap_zero_o (gap_zero),
    .gap_hit_o  (gap_hit),
    .slot_end_o (slot_end)
  );

  // A pause landing on a transition cycle holds the counter there, so the
  // transition fires on the first counting cycle after release.
  always_comb begin
    cnt_en = ((state_q == ST_SOUND) || (state_q == ST_GAP)) && !stop_i &&
             !(pause_i && (gap_hit || slot_end));
  end

  always_comb begin
    state_d   = state_q;
    resume_d  = resume_q;
    idx_d     = idx_q;
    note_on_d = 1'b0;
    done_d    = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;

    if (stop_i) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else if (start_i) begin
      state_d   = ST_SOUND;
      idx_d     = '0;
      load      = 1'b1;
      note_on_d = 1'b1;
    end else begin
      case (state_q)
        ST_SOUND: begin
          if (pause_i) begin
            state_d  = ST_PAUSED;
            resume_d = ST_SOUND;
          end else if (gap_hit) begin
            state_d = ST_GAP;
          end else if (gap_zero && slot_end) begin
            advance = 1'b1;
          end
        end
        ST_GAP: begin
          if (pause_i) begin
            state_d  = ST_PAUSED;
            resume_d = ST_GAP;
          end else if (slot_end) begin
            advance = 1'b1;
          end
        end
        ST_PAUSED: begin
          if (!pause_i) begin
            state_d = resume_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (advance) begin
        if (idx_q != LAST_IDX) begin
          idx_d     = idx_q + IDX_BW'(1);
          state_d   = ST_SOUND;
          load      = 1'b1;
          note_on_d = 1'b1;
        end else if (loop_i) begin
          idx_d     = '0;
          state_d   = ST_SOUND;
          load      = 1'b1;
          note_on_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    end

    gate_d = (state_d == ST_SOUND);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      resume_q  <= ST_SOUND;
      idx_q     <= '0;
      note_on_q <= 1'b0;
      gate_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      resume_q  <= resume_d;
      idx_q     <= idx_d;
      note_on_q <= note_on_d;
      gate_q    <= gate_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign note_index_o = idx_q;
  assign note_on_o    = note_on_q;
  assign gate_o       = gate_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_note_sequencer_ctrl.sv
// Scoreboard bench for note_sequencer_ctrl with SEQ_LEN=4, tempo 10, gap 3.
module tb_note_sequencer_ctrl;

  typedef struct packed {
    logic       note_on;
    logic [5:0] idx;
    logic       gate;
    logic       busy;
    logic       done;
  } obs_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic        pause;
  logic        loop_en;
  logic [23:0] tempo;
  logic [23:0] gap;
  logic [5:0]  note_index;
  logic        note_on;
  logic        gate;
  logic        busy;
  logic        done;

  int   tests;
  int   failed;
  obs_t exp_q[$];

  note_sequencer_ctrl #(
    .CNT_BW (24),
    .IDX_BW (6),
    .SEQ_LEN(4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .stop_i      (stop),
    .pause_i     (pause),
    .loop_i      (loop_en),
    .tempo_i     (tempo),
    .gap_i       (gap),
    .note_index_o(note_index),
    .note_on_o   (note_on),
    .gate_o      (gate),
    .busy_o      (busy),
    .done_o      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o.note_on = note_on;
    o.idx     = note_index;
    o.gate    = gate;
    o.busy    = busy;
    o.done    = done;
    return o;
  endfunction

  // Expected outputs t cycles after a start with a 10-cycle slot over 4 notes.
  function automatic obs_t slot_model(int t, int gate_len, bit looping);
    obs_t o;
    int   slot;
    int   pos;
    bit   active;
    slot      = (t - 1) / 10;
    pos       = (t - 1) % 10;
    active    = looping || (t < 41);
    o.note_on = active && (pos == 0);
    o.idx     = active ? 6'(slot % 4) : 6'd3;
    o.gate    = active && (pos < gate_len);
    o.busy    = active;
    o.done    = !looping && (t == 41);
    return o;
  endfunction

  function automatic obs_t idle_obs(logic [5:0] idx);
    obs_t o;
    o         = '0;
    o.idx     = idx;
    return o;
  endfunction

  task automatic do_reset();
    start = 1'b0; stop = 1'b0; pause = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_seq();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++; if (note_index !== 6'd0) begin failed++; $display("FAIL reset_idx got=%0d want=0", note_index); end
    tests++; if (note_on !== 1'b0) begin failed++; $display("FAIL reset_note_on got=%b want=0", note_on); end
    tests++; if (gate !== 1'b0) begin failed++; $display("FAIL reset_gate got=%b want=0", gate); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got=%b want=0", busy); end
    tests++; if (done !== 1'b0) begin failed++; $display("FAIL reset_done got=%b want=0", done); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (sample() !== idle_obs(6'd0)) begin
        failed++; $display("FAIL reset_idle i=%0d got=%b want=%b", i, sample(), idle_obs(6'd0));
      end
    end
  endtask

  task automatic test_basic();
    obs_t e;
    do_reset();
    for (int t = 1; t <= 50; t++) exp_q.push_back(slot_model(t, 7, 1'b0));
    start_seq();
    for (int t = 1; t <= 50; t++) begin
      e = exp_q.pop_front();
      tests++;
      if (sample() !== e) begin failed++; $display("FAIL basic t=%0d got=%b want=%b", t, sample(), e); end
      @(negedge clk);
    end
  endtask

  task automatic test_loop();
    obs_t e;
    do_reset();
    loop_en = 1'b1;
    for (int t = 1; t <= 100; t++) exp_q.push_back(slot_model(t, 7, 1'b1));
    exp_q.push_back(idle_obs(6'd0));
    start_seq();
    for (int t = 1; t <= 100; t++) begin
      e = exp_q.pop_front();
      tests++;
      if (sample() !== e) begin failed++; $display("FAIL loop t=%0d got=%b want=%b", t, sample(), e); end
      stop = (t == 100);
      @(negedge clk);
    end
    stop = 1'b0;
    loop_en = 1'b0;
    e = exp_q.pop_front();
    tests++;
    if (sample() !== e) begin failed++; $display("FAIL loop_stop got=%b want=%b", sample(), e); end
  endtask

  task automatic test_pause();
    obs_t e;
    obs_t paused;
    do_reset();
    paused      = '0;
    paused.busy = 1'b1;
    for (int t = 1; t <= 45; t++) begin
      if (t <= 5)       exp_q.push_back(slot_model(t, 7, 1'b0));
      else if (t <= 15) exp_q.push_back(paused);
      else              exp_q.push_back(slot_model(t - 10, 7, 1'b0));
    end
    start_seq();
    for (int t = 1; t <= 45; t++) begin
      e = exp_q.pop_front();
      tests++;
      if (sample() !== e) begin failed++; $display("FAIL pause t=%0d got=%b want=%b", t, sample(), e); end
      pause = (t >= 5) && (t <= 14);
      @(negedge clk);
    end
    pause = 1'b0;
  endtask

  task automatic test_clamp_tempo();
    obs_t e;
    obs_t o;
    do_reset();
    tempo = 24'd0;
    for (int t = 1; t <= 8; t++) begin
      o = '0;
      if (t <= 4) begin
        o.note_on = 1'b1; o.idx = 6'(t - 1); o.gate = 1'b1; o.busy = 1'b1;
      end else begin
        o.idx = 6'd3; o.done = (t == 5);
      end
      exp_q.push_back(o);
    end
    start_seq();
    for (int t = 1; t <= 8; t++) begin
      e = exp_q.pop_front();
      tests++;
      if (sample() !== e) begin failed++; $display("FAIL clamp_tempo t=%0d got=%b want=%b", t, sample(), e); end
      @(negedge clk);
    end
    tempo = 24'd10;
  endtask

  task automatic test_clamp_gap();
    obs_t e;
    do_reset();
    gap = 24'd20;
    for (int t = 1; t <= 45; t++) exp_q.push_back(slot_model(t, 1, 1'b0));
    start_seq();
    for (int t = 1; t <= 45; t++) begin
      e = exp_q.pop_front();
      tests++;
      if (sample() !== e) begin failed++; $display("FAIL clamp_gap t=%0d got=%b want=%b", t, sample(), e); end
      @(negedge clk);
    end
    gap = 24'd3;
  endtask

  task automatic test_stop_start();
    obs_t e;
    do_reset();
    for (int t = 1; t <= 3; t++) exp_q.push_back(slot_model(t, 7, 1'b0));
    for (int t = 4; t <= 8; t++) exp_q.push_back(idle_obs(6'd0));
    start_seq();
    for (int t = 1; t <= 8; t++) begin
      e = exp_q.pop_front();
      tests++;
      if (sample() !== e) begin failed++; $display("FAIL stop_start t=%0d got=%b want=%b", t, sample(), e); end
      stop  = (t == 3);
      start = (t == 3);
      @(negedge clk);
    end
    stop = 1'b0; start = 1'b0;
  endtask

  task automatic test_back_to_back();
    obs_t e;
    do_reset();
    for (int t = 1; t <= 40; t++) begin
      if (t <= 25) exp_q.push_back(slot_model(t, 7, 1'b0));
      else         exp_q.push_back(slot_model(t - 25, 7, 1'b0));
    end
    start_seq();
    for (int t = 1; t <= 40; t++) begin
      e = exp_q.pop_front();
      tests++;
      if (sample() !== e) begin failed++; $display("FAIL restart t=%0d got=%b want=%b", t, sample(), e); end
      start = (t == 25);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_async_reset();
    obs_t e;
    do_reset();
    for (int t = 1; t <= 9; t++) exp_q.push_back(slot_model(t, 7, 1'b0));
    start_seq();
    for (int t = 1; t <= 9; t++) begin
      e = exp_q.pop_front();
      tests++;
      if (sample() !== e) begin failed++; $display("FAIL async_pre t=%0d got=%b want=%b", t, sample(), e); end
      if (t < 9) @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (sample() !== idle_obs(6'd0)) begin
      failed++; $display("FAIL async_reset got=%b want=%b", sample(), idle_obs(6'd0));
    end
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      tests++;
      if (sample() !== idle_obs(6'd0)) begin
        failed++; $display("FAIL async_after t=%0d got=%b want=%b", t, sample(), idle_obs(6'd0));
      end
    end
  endtask

  initial begin
    tests   = 0;
    failed  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    stop    = 1'b0;
    pause   = 1'b0;
    loop_en = 1'b0;
    tempo   = 24'd10;
    gap     = 24'd3;
    test_reset();
    test_basic();
    test_loop();
    test_pause();
    test_clamp_tempo();
    test_clamp_gap();
    test_stop_start();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
